// File: rtl/guess_pkg.sv
// Shared types and constants for the guess entry keypad front-end.
package guess_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    PEND  = 1'b1
  } state_t;

  localparam logic [3:0]  KEY_BS     = 4'hA;
  localparam logic [3:0]  KEY_ENT    = 4'hB;
  localparam logic [3:0]  KEY_CLR    = 4'hC;
  localparam logic [3:0]  BLANK      = 4'hF;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [2:0]  FULL_CNT   = 3'(NUM_DIGITS);

  // Position 0 is the most significant nibble (first-entered digit).
  function automatic logic [15:0] set_nibble(input logic [15:0] v,
                                             input logic [1:0]  pos,
                                             input logic [3:0]  val);
    logic [15:0] r;
    r = v;
    case (pos)
      2'd0:    r[15:12] = val;
      2'd1:    r[11:8]  = val;
      2'd2:    r[7:4]   = val;
      default: r[3:0]   = val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/guess_entry_dup_detect.sv
// Combinational check: does a new digit match any of the first digit_cnt entered digits.
module dup_detect (
  input  logic [15:0] entry,
  input  logic [2:0]  digit_cnt,
  input  logic [3:0]  digit,
  output logic        hit
);
  import guess_pkg::*;

  logic [3:0] nib;

  always_comb begin
    hit = 1'b0;
    nib = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib = 4'(entry >> (12 - 4 * i));
      if ((i < 32'(digit_cnt)) && (nib == digit))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Four-digit keypad guess entry with backspace/clear/enter and a valid/ready hand-off.
// Optional duplicate-digit rejection is enabled by defining GUESS_DUP_CHECK_EN.
module guess_entry #(
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        guess_ready,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic [15:0] disp,
  output logic [2:0]  digit_cnt,
  output logic        err
);
  import guess_pkg::*;

  localparam logic [3:0] MAX_CODE = 4'(MAX_DIGIT);

  state_t      state, state_n;
  logic [15:0] disp_n, guess_n;
  logic [2:0]  cnt_n, cnt_m1;
  logic        gv_n, err_n;
  logic        dup;

`ifdef GUESS_DUP_CHECK_EN
  dup_detect u_dup (
    .entry     (disp),
    .digit_cnt (digit_cnt),
    .digit     (key_code),
    .hit       (dup)
  );
`else
  assign dup = 1'b0;
`endif

  assign cnt_m1 = digit_cnt - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENTRY;
      disp        <= '1;
      digit_cnt   <= '0;
      guess       <= '0;
      guess_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      disp        <= disp_n;
      digit_cnt   <= cnt_n;
      guess       <= guess_n;
      guess_valid <= gv_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ENTRY: if (key_valid && (key_code == KEY_ENT) && (digit_cnt == FULL_CNT))
               state_n = PEND;
      PEND:  if (guess_ready)
               state_n = ENTRY;
      default: state_n = ENTRY;
    endcase
  end

  // Commands are decoded ahead of digits so A/B/C keep their meaning for any MAX_DIGIT.
  always_comb begin
    disp_n  = disp;
    cnt_n   = digit_cnt;
    guess_n = guess;
    gv_n    = guess_valid;
    err_n   = 1'b0;
    case (state)
      ENTRY: begin
        if (key_valid) begin
          if (key_code == KEY_CLR) begin
            disp_n = '1;
            cnt_n  = '0;
          end else if (key_code == KEY_BS) begin
            if (digit_cnt != 3'd0) begin
              disp_n = set_nibble(disp, cnt_m1[1:0], BLANK);
              cnt_n  = cnt_m1;
            end else begin
              err_n = 1'b1;
            end
          end else if (key_code == KEY_ENT) begin
            if (digit_cnt == FULL_CNT) begin
              guess_n = disp;
              gv_n    = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else if ((key_code <= MAX_CODE) && (digit_cnt != FULL_CNT) && !dup) begin
            disp_n = set_nibble(disp, digit_cnt[1:0], key_code);
            cnt_n  = digit_cnt + 3'd1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      PEND: begin
        err_n = key_valid;
        if (guess_ready) begin
          gv_n   = 1'b0;
          disp_n = '1;
          cnt_n  = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL have parameter MAX_DIGIT, default 9: highest digit value accepted as a digit key.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-005 SHALL have port key_code  input  4  0..MAX_DIGIT digit; 4'hA backspace; 4'hB enter; 4'hC clear; other codes illegal.
REQ-006 SHALL have port guess_ready  input  1  downstream (checker stage) accepts guess.
REQ-007 SHALL have port guess  output  16  four BCD digits; first-entered digit in [15:12].
REQ-008 SHALL have port guess_valid  output  1  guess held and offered downstream.
REQ-009 SHALL have port disp  output  16  partial entry for display; unfilled positions 4'hF.
REQ-010 SHALL have port digit_cnt  output  3  digits entered, 0..4.
REQ-011 SHALL have port err  output  1  one-cycle pulse, key rejected.

Function
REQ-012 SHALL implement two states: ENTRY (collecting digits) and PEND (guess offered, awaiting guess_ready).
REQ-013 In ENTRY, an accepted digit with digit_cnt=N<4 SHALL write disp nibble N (N=0 is [15:12]) and increment digit_cnt, both visible the cycle after the key.
REQ-014 A digit key with digit_cnt=4, a code above MAX_DIGIT other than A/B/C, or code D..F SHALL be ignored and pulse err.
REQ-015 Backspace with digit_cnt>0 SHALL set the last filled nibble to 4'hF and decrement digit_cnt; with digit_cnt=0 SHALL pulse err.
REQ-016 Clear SHALL set disp to 16'hFFFF and digit_cnt to 0 without err.
REQ-017 Enter with digit_cnt=4 SHALL copy disp to guess, assert guess_valid next cycle and enter PEND; enter with digit_cnt<4 SHALL pulse err, no state change.
REQ-018 In PEND, guess and guess_valid SHALL hold stable until a cycle with guess_ready=1; on that edge guess_valid deasserts, disp returns to 16'hFFFF, digit_cnt to 0, state to ENTRY.
REQ-019 Any key_valid in PEND SHALL be ignored with err pulse, including one coincident with guess_ready.
REQ-020 guess_valid, err, disp, digit_cnt, guess SHALL be registered; no combinational path from any input to any output.
REQ-021 err SHALL be high for exactly one cycle per rejected key; key_valid held high SHALL count as one key per cycle.

Reset
REQ-022 Asserting rst_n low SHALL immediately force: state ENTRY, disp 16'hFFFF, digit_cnt 0, guess 16'h0000, guess_valid 0, err 0.
REQ-023 Reset during PEND SHALL drop guess_valid without handshake; the pending guess is discarded.
REQ-024 First key accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro GUESS_DUP_CHECK_EN defined: a digit equal to any already-entered digit SHALL be ignored with err pulse, digit_cnt unchanged.
REQ-026 Macro undefined: duplicate digits SHALL be accepted as any other digit; no duplicate logic present.

Structure
REQ-027 Shared package guess_pkg SHALL hold the state enum, key constants KEY_BS=4'hA, KEY_ENT=4'hB, KEY_CLR=4'hC, BLANK=4'hF, and NUM_DIGITS=4.
REQ-028 Duplicate detection SHALL be a combinational sub-module dup_detect (16-bit entry, digit_cnt, new digit -> hit), instantiated only under GUESS_DUP_CHECK_EN.

Verification
REQ-029 Keys 1,2,3,4,B with guess_ready=0 -> disp 16'h1234, digit_cnt 4, guess 16'h1234, guess_valid held; raise guess_ready -> guess_valid low next cycle, disp 16'hFFFF.
REQ-030 Keys 5,6,A,7 -> disp 16'h57FF, digit_cnt 2; A,A,A -> third A pulses err, digit_cnt 0.
REQ-031 Keys 1,2,B -> err pulse, state ENTRY; 1,2,3,4,9 -> err on 9, disp 16'h1234.
REQ-032 GUESS_DUP_CHECK_EN: keys 3,3 -> err on second, disp 16'h3FFF; without macro -> disp 16'h33FF, no err.
REQ-033 In PEND, key 8 coincident with guess_ready=1 -> err pulse, handshake completes, disp 16'hFFFF next cycle.
REQ-034 rst_n low mid-PEND asynchronously -> guess_valid 0, guess 16'h0000, disp 16'hFFFF before next clock edge.
